// File: rtl/snoop_dispatch_arbiter.sv
// snoop_dispatch_arbiter
// Shares one packet snooper between N_CORES packetfilter cores. A free core
// is granted in round-robin order. The snooper's write and done strobes are
// then steered to that core only. Packets that arrive while no core is
// granted are dropped and counted.
module snoop_dispatch_arbiter #(
   parameter int N_CORES            = 4,
   parameter int PACKMEM_ADDR_WIDTH = 8,
   parameter int PACKMEM_DATA_WIDTH = 64,
   parameter int INC_WIDTH          = 4,
   parameter int DROP_CNT_WIDTH     = 16,
   parameter int SEL_WIDTH          = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PACKMEM_ADDR_WIDTH-1:0] sn_addr,
   input  logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data,
   input  logic                          sn_wr_en,
   input  logic [INC_WIDTH-1:0]          sn_byte_inc,
   input  logic                          sn_done,
   output logic                          sn_rdy,
   output logic [PACKMEM_ADDR_WIDTH-1:0] core_sn_addr,
   output logic [PACKMEM_DATA_WIDTH-1:0] core_sn_wr_data,
   output logic [INC_WIDTH-1:0]          core_sn_byte_inc,
   output logic [N_CORES-1:0]            core_sn_wr_en,
   output logic [N_CORES-1:0]            core_sn_done,
   input  logic [N_CORES-1:0]            core_rdy_for_sn,
   output logic [N_CORES-1:0]            core_rdy_for_sn_ack,
   output logic [SEL_WIDTH-1:0]          sel,
   output logic [DROP_CNT_WIDTH-1:0]     drop_cnt
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N_CORES - 1);

   state_t                state;
   state_t                state_next;
   logic [SEL_WIDTH-1:0]  ptr;
   logic [SEL_WIDTH-1:0]  pick;
   logic [SEL_WIDTH-1:0]  idx;
   logic                  pick_vld;

   // Next core index, wrapping at N_CORES (which need not be a power of two)
   function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] i);
      return (i == LAST_IDX) ? '0 : i + SEL_WIDTH'(1);
   endfunction

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] c);
      return (&c) ? c : c + DROP_CNT_WIDTH'(1);
   endfunction

   function automatic logic [N_CORES-1:0] onehot(input logic [SEL_WIDTH-1:0] i);
      return N_CORES'(1) << i;
   endfunction

   // Broadcast buses go to every core; only the strobes carry the selection
   assign core_sn_addr     = sn_addr;
   assign core_sn_wr_data  = sn_wr_data;
   assign core_sn_byte_inc = sn_byte_inc;

   // Round-robin search: first ready core at or after ptr, modulo N_CORES
   always_comb begin
      pick     = ptr;
      pick_vld = 1'b0;
      idx      = ptr;
      for (int i = 0; i < N_CORES; i++) begin
         idx = SEL_WIDTH'((int'(ptr) + i) % N_CORES);
         if (!pick_vld && core_rdy_for_sn[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // FSM next state: grant when any core is ready, release on packet end
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_vld) state_next = ACTIVE;
         ACTIVE:  if (sn_done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: ready flag and strobes gated to the granted core
   always_comb begin
      sn_rdy        = 1'b0;
      core_sn_wr_en = '0;
      core_sn_done  = '0;
      if (state == ACTIVE) begin
         sn_rdy = 1'b1;
         if (sn_wr_en) core_sn_wr_en = onehot(sel);
         if (sn_done)  core_sn_done  = onehot(sel);
      end
   end

   // Grant bookkeeping: selected core, one-cycle ack, round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel                 <= '0;
         ptr                 <= '0;
         core_rdy_for_sn_ack <= '0;
      end else begin
         core_rdy_for_sn_ack <= '0;
         if (state == IDLE && pick_vld) begin
            sel                 <= pick;
            core_rdy_for_sn_ack <= onehot(pick);
         end
         if (state == ACTIVE && sn_done) ptr <= next_idx(sel);
      end
   end

   // Count packets whose end arrives with no core granted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          drop_cnt <= '0;
      else if (state == IDLE && sn_done) drop_cnt <= sat_inc(drop_cnt);
   end

endmodule

// File: tb/tb_snoop_dispatch_arbiter.sv
// tb_snoop_dispatch_arbiter
// Directed, table-driven bench for snoop_dispatch_arbiter (4 cores). Each
// table row is one clock cycle: inputs plus the outputs expected in it.
// A second instance with a 2-bit drop counter exercises saturation.
module tb_snoop_dispatch_arbiter;

   typedef struct {
      logic [3:0]  rdy;
      logic        wr;
      logic        done;
      logic        exp_rdy;
      logic [3:0]  exp_ack;
      logic [1:0]  exp_sel;
      logic [3:0]  exp_wr;
      logic [3:0]  exp_done;
      logic [15:0] exp_drop;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sn_addr;
   logic [63:0] sn_wr_data;
   logic        sn_wr_en;
   logic [3:0]  sn_byte_inc;
   logic        sn_done;
   logic        sn_rdy;
   logic [7:0]  core_sn_addr;
   logic [63:0] core_sn_wr_data;
   logic [3:0]  core_sn_byte_inc;
   logic [3:0]  core_sn_wr_en;
   logic [3:0]  core_sn_done;
   logic [3:0]  core_rdy_for_sn;
   logic [3:0]  core_rdy_for_sn_ack;
   logic [1:0]  sel;
   logic [15:0] drop_cnt;

   logic        done2;
   logic        sn_rdy2;
   logic [7:0]  addr2;
   logic [63:0] data2;
   logic [3:0]  inc2;
   logic [3:0]  wr2;
   logic [3:0]  dn2;
   logic [3:0]  ack2;
   logic [1:0]  sel2;
   logic [1:0]  drop2;

   int n_run  = 0;
   int n_fail = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   snoop_dispatch_arbiter dut (
      .clk(clk), .rst(rst), .sn_addr(sn_addr), .sn_wr_data(sn_wr_data),
      .sn_wr_en(sn_wr_en), .sn_byte_inc(sn_byte_inc), .sn_done(sn_done),
      .sn_rdy(sn_rdy), .core_sn_addr(core_sn_addr), .core_sn_wr_data(core_sn_wr_data),
      .core_sn_byte_inc(core_sn_byte_inc), .core_sn_wr_en(core_sn_wr_en),
      .core_sn_done(core_sn_done), .core_rdy_for_sn(core_rdy_for_sn),
      .core_rdy_for_sn_ack(core_rdy_for_sn_ack), .sel(sel), .drop_cnt(drop_cnt)
   );

   snoop_dispatch_arbiter #(.DROP_CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst(rst), .sn_addr(sn_addr), .sn_wr_data(sn_wr_data),
      .sn_wr_en(1'b0), .sn_byte_inc(sn_byte_inc), .sn_done(done2),
      .sn_rdy(sn_rdy2), .core_sn_addr(addr2), .core_sn_wr_data(data2),
      .core_sn_byte_inc(inc2), .core_sn_wr_en(wr2), .core_sn_done(dn2),
      .core_rdy_for_sn(4'b0000), .core_rdy_for_sn_ack(ack2), .sel(sel2), .drop_cnt(drop2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] r, input logic w, input logic d,
                               input logic er, input logic [3:0] ea, input logic [1:0] es,
                               input logic [3:0] ew, input logic [3:0] ed, input logic [15:0] edr);
      vec_t v;
      v.rdy = r; v.wr = w; v.done = d;
      v.exp_rdy = er; v.exp_ack = ea; v.exp_sel = es;
      v.exp_wr = ew; v.exp_done = ed; v.exp_drop = edr;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Round-robin: all cores ready, four 3-write packets, done on the last write
      for (int p = 0; p < 4; p++) begin
         logic [3:0] s;
         logic [1:0] prev;
         s    = 4'(1 << p);
         prev = (p == 0) ? 2'd0 : 2'(p - 1);
         vecs.push_back(mk(4'hF, 1'b0, 1'b0, 1'b0, 4'h0, prev,  4'h0, 4'h0, 16'd0));
         vecs.push_back(mk(4'hF, 1'b1, 1'b0, 1'b1, s,    2'(p), s,    4'h0, 16'd0));
         vecs.push_back(mk(4'hF, 1'b1, 1'b0, 1'b1, 4'h0, 2'(p), s,    4'h0, 16'd0));
         vecs.push_back(mk(4'hF, 1'b1, 1'b1, 1'b1, 4'h0, 2'(p), s,    s,    16'd0));
      end
      // ptr back at 0: one packet to core 0 moves ptr to 1
      vecs.push_back(mk(4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd3, 4'h0, 4'h0, 16'd0));
      vecs.push_back(mk(4'h1, 1'b1, 1'b1, 1'b1, 4'h1, 2'd0, 4'h1, 4'h1, 16'd0));
      // Skip: ptr=1, only core 0 ready -> wrap-around grant to core 0
      vecs.push_back(mk(4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd0));
      vecs.push_back(mk(4'hF, 1'b1, 1'b1, 1'b1, 4'h1, 2'd0, 4'h1, 4'h1, 16'd0));
      // Drop: nobody ready, two packets end in IDLE
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd0));
      vecs.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd0));
      vecs.push_back(mk(4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd0));
      vecs.push_back(mk(4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd1));
      vecs.push_back(mk(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd1));
      vecs.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 4'h0, 4'h0, 16'd2));

      // Reset held with every core ready and strobes asserted
      rst             = 1'b0;
      core_rdy_for_sn = 4'hF;
      sn_wr_en        = 1'b1;
      sn_done         = 1'b1;
      sn_addr         = 8'hA5;
      sn_wr_data      = 64'h0123_4567_89AB_CDEF;
      sn_byte_inc     = 4'h8;
      done2           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset sn_rdy",   64'(sn_rdy),              64'h0);
      chk("reset ack",      64'(core_rdy_for_sn_ack), 64'h0);
      chk("reset drop_cnt", 64'(drop_cnt),            64'h0);
      chk("reset wr_en",    64'(core_sn_wr_en),       64'h0);
      chk("reset done",     64'(core_sn_done),        64'h0);
      chk("reset sel",      64'(sel),                 64'h0);
      chk("bcast addr",     64'(core_sn_addr),        64'hA5);
      chk("bcast data",     core_sn_wr_data,          64'h0123_4567_89AB_CDEF);
      chk("bcast inc",      64'(core_sn_byte_inc),    64'h8);
      rst      = 1'b1;
      sn_wr_en = 1'b0;
      sn_done  = 1'b0;

      foreach (vecs[i]) begin
         core_rdy_for_sn = vecs[i].rdy;
         sn_wr_en        = vecs[i].wr;
         sn_done         = vecs[i].done;
         #1;
         chk($sformatf("v%0d sn_rdy", i), 64'(sn_rdy),              64'(vecs[i].exp_rdy));
         chk($sformatf("v%0d ack", i),    64'(core_rdy_for_sn_ack), 64'(vecs[i].exp_ack));
         chk($sformatf("v%0d sel", i),    64'(sel),                 64'(vecs[i].exp_sel));
         chk($sformatf("v%0d wr_en", i),  64'(core_sn_wr_en),       64'(vecs[i].exp_wr));
         chk($sformatf("v%0d done", i),   64'(core_sn_done),        64'(vecs[i].exp_done));
         chk($sformatf("v%0d drop", i),   64'(drop_cnt),            64'(vecs[i].exp_drop));
         tick();
      end

      // Reset mid-packet: ptr is 1, so core 1 is granted
      core_rdy_for_sn = 4'hF;
      sn_wr_en        = 1'b0;
      sn_done         = 1'b0;
      tick();
      chk("mid grant sel", 64'(sel),                 64'h1);
      chk("mid grant ack", 64'(core_rdy_for_sn_ack), 64'h2);
      sn_wr_en = 1'b1;
      #1;
      chk("mid wr1", 64'(core_sn_wr_en), 64'h2);
      tick();
      chk("mid wr2", 64'(core_sn_wr_en), 64'h2);
      tick();
      chk("mid wr3 before reset", 64'(core_sn_wr_en), 64'h2);
      #2;
      rst = 1'b0;
      #1;
      chk("async rst sn_rdy", 64'(sn_rdy),        64'h0);
      chk("async rst sel",    64'(sel),           64'h0);
      chk("async rst wr_en",  64'(core_sn_wr_en), 64'h0);
      chk("async rst drop",   64'(drop_cnt),      64'h0);
      #1;
      rst      = 1'b1;
      sn_wr_en = 1'b0;
      tick();
      chk("post rst ack", 64'(core_rdy_for_sn_ack), 64'h1);
      chk("post rst sel", 64'(sel),                 64'h0);

      // Saturation of a 2-bit drop counter
      done2 = 1'b1;
      tick();
      tick();
      chk("sat drop2 mid", 64'(drop2), 64'h2);
      repeat (3) tick();
      chk("sat drop2 end", 64'(drop2), 64'h3);
      chk("sat no strobes", 64'(dn2), 64'h0);
      done2 = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
